uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling 8N1 UART receiver with held output byte, framing and
//            overrun flags. Define UART_RX_PARITY_EN to add an even-parity bit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  logic [1:0]         sync_q,  sync_d;
  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]         bit_q,   bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               hold_q,  hold_d;
  logic [7:0]         data_q,  data_d;
  logic               valid_q, valid_d;
  logic               fe_q,    fe_d;
  logic               ovr_q,   ovr_d;
`ifdef UART_RX_PARITY_EN
  logic               par_q,   par_d;
  logic               pe_q,    pe_d;
`endif

  logic w_rx_s;
  logic w_tick;
  logic w_stop;
  logic w_good;

  assign sync_d = {sync_q[0], rx};
  assign w_rx_s = sync_q[1];

  // Start bit is sampled half a bit in; every later bit a full bit after that.
  assign w_tick = (state_q == c_START) ? (cnt_q == c_HALF_M1)
                : (state_q != c_IDLE) && (cnt_q == c_FULL_M1);
  assign w_stop = enable && (state_q == c_STOP) && w_tick;
`ifdef UART_RX_PARITY_EN
  assign w_good = w_stop && w_rx_s && !par_q;
`else
  assign w_good = w_stop && w_rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= c_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      hold_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE:   if (!w_rx_s && !hold_q) state_d = c_START;
        c_START:  if (w_tick) state_d = w_rx_s ? c_IDLE : c_DATA;
`ifdef UART_RX_PARITY_EN
        c_DATA:   if (w_tick && bit_q == 3'd7) state_d = c_PARITY;
        c_PARITY: if (w_tick) state_d = c_STOP;
`else
        c_DATA:   if (w_tick && bit_q == 3'd7) state_d = c_STOP;
`endif
        c_STOP:   if (w_tick) state_d = c_IDLE;
        default:  state_d = c_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = w_stop && !w_rx_s;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = w_stop && par_q;
`endif

    if (!enable || state_q == c_IDLE) begin
      cnt_d = '0;
      bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
      par_d = 1'b0;
`endif
    end else if (w_tick) begin
      cnt_d = '0;
      if (state_q == c_DATA) begin
        bit_d   = bit_q + 3'd1;
        shift_d = {w_rx_s, shift_q[7:1]};
      end
`ifdef UART_RX_PARITY_EN
      if (state_q == c_DATA || state_q == c_PARITY) par_d = par_q ^ w_rx_s;
`endif
    end else begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end

    // A low stop bit may be a break; wait for the line to recover first.
    if (w_rx_s) hold_d = 1'b0;
    if (w_stop && !w_rx_s) hold_d = 1'b1;

    if (rd_en && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (w_good) begin
      if (!valid_q || rd_en) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (directed plus random frames).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Stop-bit sample cycle, counted from the first start-bit cycle on rx:
  // 2 synchronizer cycles + half bit + (NBITS-1) full bits.
  localparam int STOP_IDX = 2 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst, enable, rx, rd_en;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx(rx), .rd_en(rd_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  int n_vec = 0;
  int n_err = 0;
  int fe_hi = 0;
  int pe_hi = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1)  fe_hi <= fe_hi + 1;
    if (parity_err === 1'b1) pe_hi <= pe_hi + 1;
  end

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;
  int         m_fe = 0;
  int         m_pe = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".valid"},   {31'd0, rx_valid}, {31'd0, m_valid});
    chk({tag, ".data"},    {24'd0, rx_data},  {24'd0, m_data});
    chk({tag, ".overrun"}, {31'd0, overrun},  {31'd0, m_ovr});
    chk({tag, ".fe_cyc"},  fe_hi,             m_fe);
    chk({tag, ".pe_cyc"},  pe_hi,             m_pe);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    cyc(n);
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Drives one frame on rx and advances the reference model by its outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input bit rd_at_stop, input bit chk_timing);
    logic [10:0] seq;
    bit          par_ok;
    bit          good;
`ifdef UART_RX_PARITY_EN
    seq    = {stop_bit, par_bit, b, 1'b0};
    par_ok = ((^b) ^ par_bit) == 1'b0;
`else
    seq    = {1'b1, stop_bit, b, 1'b0};
    par_ok = 1'b1;
    if (par_bit) par_ok = 1'b1;
`endif
    for (int i = 0; i < NBITS * CPB; i++) begin
      rx = seq[i / CPB];
      if (rd_at_stop) rd_en = (i == STOP_IDX);
      if (chk_timing && i == STOP_IDX)     chk("timing.before", {31'd0, rx_valid}, 32'd0);
      if (chk_timing && i == STOP_IDX + 1) chk("timing.rise",   {31'd0, rx_valid}, 32'd1);
      cyc(1);
    end
    rd_en = 1'b0;
    good  = stop_bit && par_ok;
    if (!stop_bit) m_fe++;
    if (!par_ok)   m_pe++;
    if (good) begin
      if (!m_valid || rd_at_stop) begin
        m_data  = b;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (rd_at_stop && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Drives the leading part of a frame only; the model is left untouched.
  task automatic send_partial(input logic [7:0] b, input int ncyc);
    logic [9:0] seq;
    seq = {1'b1, b, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      rx = seq[i / CPB];
      cyc(1);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; rx = 1'b1; rd_en = 1'b0;
    m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
    cyc(3);
    chk("reset.rx_data",    {24'd0, rx_data},   32'h00);
    chk("reset.rx_valid",   {31'd0, rx_valid},  32'd0);
    chk("reset.frame_err",  {31'd0, frame_err}, 32'd0);
    chk("reset.parity_err", {31'd0, parity_err},32'd0);
    chk("reset.overrun",    {31'd0, overrun},   32'd0);
    rst = 1'b0;
    enable = 1'b1;
    idle(5);

    send_frame(8'hAA, 1'b1, even_par(8'hAA), 1'b0, 1'b1);
    chk_state("first_aa");
    do_read();
    chk("read.clears", {31'd0, rx_valid}, 32'd0);

    send_frame(8'hAA, 1'b1, even_par(8'hAA), 1'b0, 1'b0);
    chk_state("b2b_aa");
    do_read();
    send_frame(8'h18, 1'b1, even_par(8'h18), 1'b0, 1'b0);
    chk_state("b2b_18");
    do_read();

    send_frame(8'h55, 1'b1, even_par(8'h55), 1'b0, 1'b0);
    send_frame(8'h18, 1'b1, even_par(8'h18), 1'b0, 1'b0);
    chk_state("overrun_set");
    send_frame(8'h18, 1'b1, even_par(8'h18), 1'b1, 1'b0);
    chk_state("rd_at_stop");

    send_frame(8'h5A, 1'b0, even_par(8'h5A), 1'b0, 1'b0);
    idle(20);
    chk_state("frame_err");

    // Held-low line after a bad stop bit must not start a new frame.
    send_frame(8'hC3, 1'b0, even_par(8'hC3), 1'b0, 1'b0);
    rx = 1'b0;
    cyc(48);
    idle(40);
    chk_state("break");

    rx = 1'b0;
    cyc(4);
    idle(60);
    chk_state("glitch");

    do_read();
    send_partial(8'h3C, 4 * CPB + CPB / 2);
    enable = 1'b0;
    rx = 1'b1;
    cyc(1);
    enable = 1'b1;
    idle(10);
    chk_state("enable_drop");
    send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b0, 1'b0);
    chk_state("after_enable");

    send_partial(8'h3C, 4 * CPB + CPB / 2);
    rst = 1'b1;
    rx = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
    idle(10);
    chk_state("reset_mid");
    send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b0, 1'b0);
    chk_state("after_reset");
    do_read();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_state("par_ok");
    do_read();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk_state("par_bad");
`endif

    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic       sb;
      logic       pb;
      int         mode;
      b    = 8'($urandom);
      sb   = ($urandom_range(0, 4) != 0);
      pb   = even_par(b) ^ ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 2);
      if (mode == 1) do_read();
      send_frame(b, sb, pb, mode == 2, 1'b0);
      idle($urandom_range(0, 5) + (sb ? 0 : 4));
      chk_state("random");
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
